cactus_spawner: RTL and testbench

Obstacle generator for the dino runner game: the producer side of the cactus position interface consumed by `collision_detector`. It spawns one cactus at a time at the right screen edge, with pseudo-random height, width and spacing, and scrolls it left on every frame tick. It freezes on collision and reports each cactus that passes the dino for scoring. It sits between the frame-tick generator and `collision_detector` / the pixel renderer.

---
 rtl/cactus_spawner.sv | 215 +++++++++++++++++++++
 tb/tb_cactus_spawner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cactus_spawner.sv
// cactus_spawner: obstacle generator for the dino runner game.
// Spawns one cactus at a time at the right screen edge. Height, width and
// spacing come from a free-running LFSR. The cactus scrolls left once per
// frame tick. The block freezes on collision and pulses cactus_passed once
// for each cactus that gets past the dino.
// Optional feature macro: CACTUS_SPEEDUP_EN. When it is defined, the scroll
// step grows by one pixel after every SPEEDUP_PASSES passes, up to level 7.
module cactus_spawner #(
    parameter int          SCREEN_W       = 320,
    parameter logic [8:0]  GROUND_Y       = 9'd15,
    parameter int          DINO_X         = 50,
    parameter int          MIN_GAP        = 8,
    parameter int          BASE_STEP      = 2,
    parameter int          SPEEDUP_PASSES = 4,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       start,
    input  logic       collision_detect,
    output logic [8:0] cactusX,
    output logic [8:0] cactusY,
    output logic [5:0] cactusHeight,
    output logic [5:0] cactusWidth,
    output logic       cactus_valid,
    output logic       cactus_passed,
    output logic       frozen
);

    // The gap counter must hold MIN_GAP plus a 4-bit random extension.
    localparam int         GAP_W    = $clog2(MIN_GAP + 16);
    localparam logic [8:0] X_PARK   = 9'(SCREEN_W - 1);
    localparam logic [9:0] DINO_SUM = 10'(DINO_X);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SCROLL,
        S_FROZEN
    } state_t;

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [8:0]       r_x;
    logic [5:0]       r_h;
    logic [5:0]       r_w;
    logic             r_valid;
    logic             r_passed;
    logic             r_frozen;
    logic [GAP_W-1:0] r_gap;
    logic             r_reported;

    logic [15:0]      w_lfsr_next;
    logic [8:0]       w_step;
    logic [8:0]       w_x_moved;
    logic [9:0]       w_sum_old;
    logic [9:0]       w_sum_new;
    logic             w_despawn;
    logic             w_cross;
    logic             w_scroll_tick;
    logic             w_pass_now;
    logic             w_restart;
    logic [5:0]       w_spawn_h;
    logic [5:0]       w_spawn_w;
    logic [GAP_W-1:0] w_gap_reload;

    // Galois LFSR, x^16+x^14+x^13+x^11, shifting right.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // Free-running random source, independent of the game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Spawn attributes: height 16/24/32/40, width 10 or 14.
    assign w_spawn_h    = 6'd16 + {1'b0, r_lfsr[1:0], 3'b000};
    assign w_spawn_w    = r_lfsr[2] ? 6'd14 : 6'd10;
    assign w_gap_reload = GAP_INIT + GAP_W'(r_lfsr[6:3]);

`ifdef CACTUS_SPEEDUP_EN
    localparam int PC_W = $clog2(SPEEDUP_PASSES + 1);

    logic [2:0]      r_speed;
    logic [PC_W-1:0] r_pass_cnt;

    assign w_step = 9'(BASE_STEP) + {6'd0, r_speed};

    // Count passes and raise the speed level every SPEEDUP_PASSES of them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_speed    <= 3'd0;
            r_pass_cnt <= '0;
        end else if (w_restart) begin
            r_speed    <= 3'd0;
            r_pass_cnt <= '0;
        end else if (w_pass_now) begin
            if (r_pass_cnt == PC_W'(SPEEDUP_PASSES - 1)) begin
                r_pass_cnt <= '0;
                if (r_speed != 3'd7) begin
                    r_speed <= r_speed + 3'd1;
                end
            end else begin
                r_pass_cnt <= r_pass_cnt + PC_W'(1);
            end
        end
    end
`else
    // Constant scroll speed; the speed-up count has no effect in this build.
    logic w_unused_speedup;
    assign w_unused_speedup = (SPEEDUP_PASSES != 0);
    assign w_step           = 9'(BASE_STEP);
`endif

    // Movement is only applied when x >= step, so the subtraction never wraps
    // where it is used. Sums are 10 bits so x + width cannot overflow.
    assign w_despawn  = (r_x < w_step);
    assign w_x_moved  = r_x - w_step;
    assign w_sum_old  = {1'b0, r_x} + {4'b0000, r_w};
    assign w_sum_new  = {1'b0, w_x_moved} + {4'b0000, r_w};
    assign w_cross    = (w_sum_old >= DINO_SUM) && (w_sum_new < DINO_SUM);

    // Collision beats the tick: a colliding cycle neither moves nor reports.
    assign w_scroll_tick = (r_state == S_SCROLL) && game_tick && !collision_detect;
    // A cactus is reported once: when it crosses the dino, or when it leaves
    // the screen without having been reported.
    assign w_pass_now    = w_scroll_tick && !r_reported && (w_despawn || w_cross);
    assign w_restart     = (r_state == S_FROZEN) && start;

    // Game FSM with all cactus outputs held in registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_x        <= X_PARK;
            r_h        <= 6'd0;
            r_w        <= 6'd0;
            r_valid    <= 1'b0;
            r_passed   <= 1'b0;
            r_frozen   <= 1'b0;
            r_gap      <= GAP_INIT;
            r_reported <= 1'b0;
        end else begin
            r_passed <= w_pass_now;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gap   <= GAP_INIT;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (collision_detect) begin
                        r_frozen <= 1'b1;
                        r_state  <= S_FROZEN;
                    end else if (game_tick) begin
                        if (r_gap == '0) begin
                            r_x        <= X_PARK;
                            r_h        <= w_spawn_h;
                            r_w        <= w_spawn_w;
                            r_valid    <= 1'b1;
                            r_reported <= 1'b0;
                            r_state    <= S_SCROLL;
                        end else begin
                            r_gap <= r_gap - GAP_W'(1);
                        end
                    end
                end
                S_SCROLL: begin
                    if (collision_detect) begin
                        r_frozen <= 1'b1;
                        r_state  <= S_FROZEN;
                    end else if (game_tick) begin
                        if (w_despawn) begin
                            r_valid <= 1'b0;
                            r_x     <= X_PARK;
                            r_gap   <= w_gap_reload;
                            r_state <= S_GAP;
                        end else begin
                            r_x <= w_x_moved;
                        end
                        if (w_pass_now) begin
                            r_reported <= 1'b1;
                        end
                    end
                end
                S_FROZEN: begin
                    if (w_restart) begin
                        r_valid  <= 1'b0;
                        r_x      <= X_PARK;
                        r_gap    <= GAP_INIT;
                        r_frozen <= 1'b0;
                        r_state  <= S_GAP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cactusX       = r_x;
    assign cactusY       = GROUND_Y;
    assign cactusHeight  = r_h;
    assign cactusWidth   = r_w;
    assign cactus_valid  = r_valid;
    assign cactus_passed = r_passed;
    assign frozen        = r_frozen;

endmodule

// File: tb/tb_cactus_spawner.sv
// Testbench for cactus_spawner: a vector table for the control corners, then
// hand-written multi-cycle sequences for scrolling, passing, despawn,
// collision freeze, long runs and reset in the middle of a scroll.
module tb_cactus_spawner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_tick = 1'b0;
    logic       start = 1'b0;
    logic       coll = 1'b0;

    logic [8:0] x, y, x0, y0;
    logic [5:0] h, w, h0, w0;
    logic       v, p, f, v0, p0, f0;

    cactus_spawner u_dut (
        .clk(clk), .reset(rst_n), .game_tick(game_tick), .start(start),
        .collision_detect(coll),
        .cactusX(x), .cactusY(y), .cactusHeight(h), .cactusWidth(w),
        .cactus_valid(v), .cactus_passed(p), .frozen(f)
    );

    // Second instance with the dino at x=0: no cactus ever crosses it, so
    // every cactus is reported at despawn instead.
    cactus_spawner #(.DINO_X(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .game_tick(game_tick), .start(start),
        .collision_detect(coll),
        .cactusX(x0), .cactusY(y0), .cactusHeight(h0), .cactusWidth(w0),
        .cactus_valid(v0), .cactus_passed(p0), .frozen(f0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pass_seen = 0;
    int lvl  = 0;
    int pcnt = 0;

    // Reference copy of the random source; m_prev is the value the design
    // used at the most recent clock edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    typedef struct {
        logic s, t, c;
        int   x;
        logic v, p, f, hw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic t, input logic c);
        @(negedge clk);
        start = s; game_tick = t; coll = c;
        @(posedge clk);
        #1;
        start = 1'b0; game_tick = 1'b0; coll = 1'b0;
    endtask

    function automatic int exp_step();
`ifdef CACTUS_SPEEDUP_EN
        return 2 + lvl;
`else
        return 2;
`endif
    endfunction

    task automatic model_pass();
        pcnt++;
        if (pcnt == 4) begin
            pcnt = 0;
            if (lvl < 7) lvl++;
        end
    endtask

    function automatic vec_t mk(input logic s, t, c, input int xx,
                                input logic vv, pp, ff, hw);
        vec_t r;
        r.s = s; r.t = t; r.c = c; r.x = xx;
        r.v = vv; r.p = pp; r.f = ff; r.hw = hw;
        return r;
    endfunction

    // Gap ticks, spawn, then scroll until despawn (or until x == stop_at).
    task automatic run_cactus(input int gap, input bit chk0, input int stop_at,
                              output int next_gap);
        int cx, cw, st, nx;
        bit rep, ep, done;
        next_gap = 8;
        for (int i = 0; i < gap; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("gap_x", int'(x), 319);
            chk("gap_valid", int'(v), 0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("spawn_x", int'(x), 319);
        chk("spawn_valid", int'(v), 1);
        chk("spawn_h", int'(h), 16 + 8 * int'(m_prev[1:0]));
        cw = m_prev[2] ? 14 : 10;
        chk("spawn_w", int'(w), cw);
        cx = 319; rep = 1'b0; done = 1'b0;
        for (int it = 0; it < 400 && !done; it++) begin
            st = exp_step();
            cyc(1'b0, 1'b1, 1'b0);
            if (p) n_pass_seen++;
            if (cx < st) begin
                chk("despawn_x", int'(x), 319);
                chk("despawn_valid", int'(v), 0);
                chk("despawn_pass", int'(p), rep ? 0 : 1);
                if (chk0) chk("despawn_pass0", int'(p0), 1);
                if (!rep) model_pass();
                next_gap = 8 + int'(m_prev[6:3]);
                done = 1'b1;
            end else begin
                nx = cx - st;
                ep = !rep && (cx + cw >= 50) && (nx + cw < 50);
                chk("scroll_x", int'(x), nx);
                chk("scroll_valid", int'(v), 1);
                chk("scroll_pass", int'(p), int'(ep));
                if (chk0) chk("scroll_pass0", int'(p0), 0);
                if (ep) begin
                    rep = 1'b1;
                    model_pass();
                end
                cx = nx;
                if (stop_at != 0 && cx == stop_at) done = 1'b1;
            end
        end
        if (!done) chk("scroll_bound", 0, 1);
    endtask

    initial begin
        int g;
        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(x), 319);
        chk("rst_y", int'(y), 15);
        chk("rst_h", int'(h), 0);
        chk("rst_w", int'(w), 0);
        chk("rst_valid", int'(v), 0);
        chk("rst_passed", int'(p), 0);
        chk("rst_frozen", int'(f), 0);
        @(negedge clk);
        rst_n = 1'b1;

        //              s     t     c     x    v     p     f     hw
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 319, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 317, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 317, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 315, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 315, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 315, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 315, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 315, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 319, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 319, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            cyc(vecs[i].s, vecs[i].t, vecs[i].c);
            chk($sformatf("vec%0d_x", i), int'(x), vecs[i].x);
            chk($sformatf("vec%0d_valid", i), int'(v), int'(vecs[i].v));
            chk($sformatf("vec%0d_passed", i), int'(p), int'(vecs[i].p));
            chk($sformatf("vec%0d_frozen", i), int'(f), int'(vecs[i].f));
            if (vecs[i].hw) begin
                chk($sformatf("vec%0d_h", i), int'(h), 16 + 8 * int'(m_prev[1:0]));
                chk($sformatf("vec%0d_w", i), int'(w), m_prev[2] ? 14 : 10);
            end
        end

        // Full cactus life, including the despawn-time report on u_dut0
        run_cactus(8, 1'b1, 0, g);

        // Collision with a tick at x=61: frozen, position held
        run_cactus(g, 1'b0, 61, g);
        cyc(1'b0, 1'b1, 1'b1);
        chk("coll_x", int'(x), 61);
        chk("coll_frozen", int'(f), 1);
        chk("coll_passed", int'(p), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("frozen_x", int'(x), 61);
            chk("frozen_f", int'(f), 1);
            chk("frozen_valid", int'(v), 1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_valid", int'(v), 0);
        chk("restart_x", int'(x), 319);
        chk("restart_frozen", int'(f), 0);
        lvl = 0; pcnt = 0;

        // Thirty cacti: step tracked by the scroll checks
        g = 8;
        n_pass_seen = 0;
        for (int k = 0; k < 30; k++) run_cactus(g, 1'b0, 0, g);
        chk("passes30", n_pass_seen, 30);

        // Reset asserted in the middle of a scroll takes effect at once
        run_cactus(g, 1'b0, 301, g);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 319);
        chk("midrst_valid", int'(v), 0);
        chk("midrst_h", int'(h), 0);
        chk("midrst_w", int'(w), 0);
        chk("midrst_frozen", int'(f), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lvl = 0; pcnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_valid", int'(v), 0);
        run_cactus(8, 1'b0, 0, g);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
